// File: rtl/n64_pif_pkg.sv
// Shared PIF RAM / serial-interface definitions: block geometry, SI state
// encoding and transfer-direction constants.
package n64_pif_pkg;

  localparam int unsigned PIF_ADDR_W      = 9;
  localparam int unsigned PIF_BURST_WORDS = 16;
  localparam logic [PIF_ADDR_W-1:0] PIF_BASE_WORD = 9'h1F0;  // byte 0x7C0

  localparam logic SI_DIR_READ  = 1'b0;  // PIF RAM -> outbound stream
  localparam logic SI_DIR_WRITE = 1'b1;  // inbound stream -> PIF RAM

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } si_state_e;

endpackage

// File: rtl/si_word_fifo2.sv
// Two-entry register FIFO for the SI read path.
// Ports:
//   clk, reset          clock, synchronous active-high reset (empties FIFO)
//   push, push_data     write one word (caller guarantees not full unless popping)
//   pop                 drop the head word (caller guarantees head_valid)
//   head_data/valid     registered head of queue
//   count_c             current occupancy 0..2 (decoded from valid flags)
module si_word_fifo2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [1:0]       count_c
);

  logic [WIDTH-1:0] tail_data_q;
  logic             tail_valid_q;

  assign count_c = {head_valid & tail_valid_q, head_valid ^ tail_valid_q};

  // Head/tail shift register; a pop shifts the tail (or the incoming word) to the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_data    <= '0;
      head_valid   <= 1'b0;
      tail_data_q  <= '0;
      tail_valid_q <= 1'b0;
    end else if (pop) begin
      head_data    <= tail_valid_q ? tail_data_q : push_data;
      head_valid   <= tail_valid_q | push;
      if (push) begin
        tail_data_q <= push_data;
      end
      tail_valid_q <= tail_valid_q & push;
    end else if (push) begin
      if (!head_valid) begin
        head_data  <= push_data;
        head_valid <= 1'b1;
      end else begin
        tail_data_q  <= push_data;
        tail_valid_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/n64_si_dma_ctrl.sv
// Serial-interface DMA engine on PIF RAM port B: moves one BURST_WORDS block
// between the RAM and an outbound (read) or inbound (write) word stream.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid/req_dir/req_ready     transfer request (req_ready high only in IDLE)
//   ram_addr/ram_wren/ram_wdata     port-B pins, combinational from state/counters
//   ram_rdata                       port-B read data, 1-clock latency
//   rd_data/rd_valid/rd_ready       outbound word stream (RAM -> stream)
//   wr_data/wr_valid/wr_ready       inbound word stream (stream -> RAM)
//   busy, done                      activity flag, one-clock end-of-burst pulse
module n64_si_dma_ctrl
  import n64_pif_pkg::*;
#(
  parameter int unsigned       ADDR_W      = PIF_ADDR_W,
  parameter int unsigned       BURST_WORDS = PIF_BURST_WORDS,
  parameter logic [ADDR_W-1:0] BASE_WORD   = ADDR_W'(PIF_BASE_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_dir,
  output logic              req_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  input  logic [31:0]       wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BURST_WORDS - 1);

  si_state_e        state_q, state_d;
  logic [CNT_W-1:0] icnt_q;      // read addresses issued
  logic [CNT_W-1:0] ccnt_q;      // words completed (popped or written)
  logic             inflight_q;  // read issued last clock, data arrives now

  logic       issue_c;
  logic       pop_c;
  logic       wr_acc_c;
  logic       req_acc_c;
  logic [1:0] fifo_cnt_c;
  logic [2:0] occ_c;

  si_word_fifo2 #(.WIDTH(32)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q),
    .push_data  (ram_rdata),
    .pop        (pop_c),
    .head_data  (rd_data),
    .head_valid (rd_valid),
    .count_c    (fifo_cnt_c)
  );

  assign pop_c = rd_valid & rd_ready;
  // Slots committed after this edge; a pop this clock frees one for a new issue.
  assign occ_c = 3'(fifo_cnt_c) + 3'(inflight_q) - 3'(pop_c);

  // Next state and combinational RAM port-B drive.
  always_comb begin
    state_d   = state_q;
    issue_c   = 1'b0;
    wr_acc_c  = 1'b0;
    req_acc_c = 1'b0;
    ram_addr  = BASE_WORD;
    ram_wren  = 1'b0;
    ram_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          req_acc_c = 1'b1;
          state_d   = (req_dir == SI_DIR_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ: begin
        if ((icnt_q < BURST_CNT) && (occ_c < 3'd2)) begin
          issue_c  = 1'b1;
          ram_addr = BASE_WORD + icnt_q[ADDR_W-1:0];
        end
        if (pop_c && (ccnt_q == LAST_CNT)) begin
          state_d = ST_DONE;
        end
      end
      ST_WRITE: begin
        if (wr_valid && wr_ready) begin
          wr_acc_c  = 1'b1;
          // A reset in this clock aborts the burst without touching the RAM.
          ram_wren  = ~reset;
          ram_addr  = BASE_WORD + ccnt_q[ADDR_W-1:0];
          ram_wdata = wr_data;
          if (ccnt_q == LAST_CNT) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_ready  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_ready <= (state_d == ST_IDLE);
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      wr_ready  <= (state_d == ST_WRITE);
    end
  end

  // Issue/completion counters and read-inflight flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      icnt_q     <= '0;
      ccnt_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue_c;
      if (req_acc_c) begin
        icnt_q <= '0;
        ccnt_q <= '0;
      end else begin
        if (issue_c) begin
          icnt_q <= icnt_q + CNT_W'(1);
        end
        if (pop_c || wr_acc_c) begin
          ccnt_q <= ccnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_n64_si_dma_ctrl.sv
// Self-checking bench for n64_si_dma_ctrl with a behavioural PIF RAM.
module tb_n64_si_dma_ctrl;
  import n64_pif_pkg::*;

  localparam int unsigned AW    = PIF_ADDR_W;
  localparam int          NW    = int'(PIF_BURST_WORDS);
  localparam int          DEPTH = 1 << AW;
  localparam logic [AW-1:0] BASE = PIF_BASE_WORD;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_dir, req_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [31:0]   rd_data;
  logic          rd_valid, rd_ready;
  logic [31:0]   wr_data;
  logic          wr_valid, wr_ready;
  logic          busy, done;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem [DEPTH];
  logic [31:0] img [DEPTH];
  logic        load;

  always #5 clk = ~clk;

  n64_si_dma_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dir   (req_dir),
    .req_ready (req_ready),
    .ram_addr  (ram_addr),
    .ram_wren  (ram_wren),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done)
  );

  // PIF RAM port B: synchronous write, registered read (1-clock latency).
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= img[a];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic preload(input int kind);
    for (int a = 0; a < DEPTH; a++) begin
      case (kind)
        0:       img[a] = 32'(a);
        1:       img[a] = $urandom;
        default: img[a] = 32'hDEAD_0000 + 32'(a);
      endcase
    end
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic start_req(input logic dir);
    req_valid = 1'b1;
    req_dir   = dir;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Drains one read burst; entered at the first negedge after the accepting edge.
  task automatic read_body(input int mode, input bit chk_lat, input string tag);
    logic [31:0] exp_w [NW];
    int got = 0;
    int first_c = -1;
    int last_c = -1;
    int max_iss = 0;
    int max_out = 0;
    int wren_seen = 0;
    int idx;
    bit hold = 1'b0;
    logic [31:0] held = '0;
    for (int i = 0; i < NW; i++) exp_w[i] = img[(int'(BASE) + i) % DEPTH];
    for (int c = 0; c < 300 && got < NW; c++) begin
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = ((c % 4) == 0) || ((c % 4) == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      wr_valid = 1'($urandom_range(0, 1));
      wr_data  = $urandom;
      #1;
      n_total++;
      if (req_ready !== 1'b0) $display("FAIL %s req_ready_busy: got %b want 0", tag, req_ready);
      else n_pass++;
      if (ram_wren === 1'b1) wren_seen++;
      idx = int'(ram_addr) - int'(BASE);
      if (idx + 1 > max_iss) max_iss = idx + 1;
      if (hold) begin
        n_total++;
        if (rd_valid !== 1'b1 || rd_data !== held)
          $display("FAIL %s stall_hold: got v=%b d=%h want v=1 d=%h", tag, rd_valid, rd_data, held);
        else n_pass++;
      end
      hold = 1'b0;
      if (rd_valid === 1'b1) begin
        if (first_c < 0) first_c = c;
        if (rd_ready) begin
          n_total++;
          if (rd_data !== exp_w[got])
            $display("FAIL %s word%0d: got %h want %h", tag, got, rd_data, exp_w[got]);
          else n_pass++;
          got++;
          last_c = c;
        end else begin
          hold = 1'b1;
          held = rd_data;
        end
      end
      if (max_iss - got > max_out) max_out = max_iss - got;
      @(negedge clk);
    end
    rd_ready = 1'b0;
    wr_valid = 1'b0;
    n_total++;
    if (got !== NW) $display("FAIL %s word_count: got %0d want %0d", tag, got, NW);
    else n_pass++;
    if (chk_lat) begin
      n_total++;
      if (first_c !== 2) $display("FAIL %s first_valid_latency: got %0d want 2", tag, first_c);
      else n_pass++;
      n_total++;
      if (last_c - first_c !== NW - 1)
        $display("FAIL %s streaming_span: got %0d want %0d", tag, last_c - first_c, NW - 1);
      else n_pass++;
    end
    n_total++;
    if (max_out > 2) $display("FAIL %s outstanding: got %0d want <=2", tag, max_out);
    else n_pass++;
    n_total++;
    if (wren_seen !== 0) $display("FAIL %s read_wren: got %0d want 0", tag, wren_seen);
    else n_pass++;
    n_total++;
    if ({done, busy, rd_valid} !== 3'b110)
      $display("FAIL %s done_pulse {done,busy,rd_valid}: got %b want 110", tag, {done, busy, rd_valid});
    else n_pass++;
  endtask

  // Feeds stop_after words with random gaps; model: every offered word is taken.
  task automatic write_body(input int stop_after, input string tag);
    int sent = 0;
    for (int c = 0; c < 300 && sent < stop_after; c++) begin
      wr_valid = ($urandom_range(0, 99) < 60);
      wr_data  = 32'hA500_0000 + 32'(sent);
      rd_ready = 1'($urandom_range(0, 1));
      #1;
      n_total++;
      if ({wr_ready, rd_valid, req_ready} !== 3'b100)
        $display("FAIL %s write_flags {wr_ready,rd_valid,req_ready}: got %b want 100", tag,
                 {wr_ready, rd_valid, req_ready});
      else n_pass++;
      n_total++;
      if (wr_valid) begin
        if ({ram_wren, ram_addr, ram_wdata} !== {1'b1, BASE + AW'(sent), wr_data})
          $display("FAIL %s ram_write%0d: got we=%b a=%h d=%h want we=1 a=%h d=%h", tag, sent,
                   ram_wren, ram_addr, ram_wdata, BASE + AW'(sent), wr_data);
        else n_pass++;
        sent++;
      end else begin
        if (ram_wren !== 1'b0) $display("FAIL %s idle_wren: got %b want 0", tag, ram_wren);
        else n_pass++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    n_total++;
    if (sent !== stop_after) $display("FAIL %s words_sent: got %0d want %0d", tag, sent, stop_after);
    else n_pass++;
  endtask

  task automatic check_idle(input string tag);
    n_total++;
    if ({done, busy, req_ready} !== 3'b001)
      $display("FAIL %s idle {done,busy,req_ready}: got %b want 001", tag, {done, busy, req_ready});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if ({req_ready, busy, done, wr_ready, rd_valid, ram_wren} !== 6'b100000)
      $display("FAIL reset_flags: got %b want 100000",
               {req_ready, busy, done, wr_ready, rd_valid, ram_wren});
    else n_pass++;
    n_total++;
    if ({ram_addr, ram_wdata} !== {BASE, 32'h0})
      $display("FAIL reset_ram_bus: got a=%h d=%h want a=%h d=0", ram_addr, ram_wdata, BASE);
    else n_pass++;
  endtask

  task automatic test_read_stream();
    preload(0);
    start_req(SI_DIR_READ);
    read_body(0, 1'b1, "rd_stream");
    @(negedge clk);
    check_idle("rd_stream");
  endtask

  task automatic test_read_stall();
    preload(1);
    start_req(SI_DIR_READ);
    read_body(1, 1'b0, "rd_stall");
    @(negedge clk);
    check_idle("rd_stall");
    preload(1);
    start_req(SI_DIR_READ);
    read_body(2, 1'b0, "rd_random");
    @(negedge clk);
    check_idle("rd_random");
  endtask

  task automatic test_write();
    start_req(SI_DIR_WRITE);
    write_body(NW, "wr_burst");
    n_total++;
    if ({done, busy, wr_ready} !== 3'b110)
      $display("FAIL wr_burst done {done,busy,wr_ready}: got %b want 110", {done, busy, wr_ready});
    else n_pass++;
    for (int i = 0; i < NW; i++) begin
      n_total++;
      if (mem[int'(BASE) + i] !== 32'hA500_0000 + 32'(i))
        $display("FAIL wr_burst mem%0d: got %h want %h", i, mem[int'(BASE) + i], 32'hA500_0000 + 32'(i));
      else n_pass++;
    end
    @(negedge clk);
    check_idle("wr_burst");
  endtask

  task automatic test_held_req();
    preload(1);
    req_valid = 1'b1;
    req_dir   = SI_DIR_READ;
    @(negedge clk);
    read_body(0, 1'b1, "held_first");
    @(negedge clk);
    check_idle("held_gap");
    @(negedge clk);
    n_total++;
    if ({busy, req_ready} !== 2'b10)
      $display("FAIL held_restart {busy,req_ready}: got %b want 10", {busy, req_ready});
    else n_pass++;
    req_valid = 1'b0;
    read_body(0, 1'b1, "held_second");
    @(negedge clk);
    check_idle("held_second");
  endtask

  task automatic test_back_to_back();
    preload(1);
    start_req(SI_DIR_READ);
    read_body(2, 1'b0, "b2b_rd");
    @(negedge clk);
    check_idle("b2b_gap");
    start_req(SI_DIR_WRITE);
    write_body(NW, "b2b_wr");
    n_total++;
    if ({done, busy} !== 2'b11) $display("FAIL b2b_wr done {done,busy}: got %b want 11", {done, busy});
    else n_pass++;
    @(negedge clk);
    check_idle("b2b_wr");
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] want;
    preload(2);
    start_req(SI_DIR_WRITE);
    write_body(5, "wr_abort");
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'hBAD0_BAD0;
    #1;
    n_total++;
    if (ram_wren !== 1'b0) $display("FAIL abort_wren: got %b want 0", ram_wren);
    else n_pass++;
    @(negedge clk);
    reset    = 1'b0;
    wr_valid = 1'b0;
    #1;
    n_total++;
    if ({req_ready, busy, done, wr_ready, rd_valid, ram_wren, ram_addr, ram_wdata} !==
        {6'b100000, BASE, 32'h0})
      $display("FAIL abort_outputs: got %b_%h_%h want 100000_%h_0",
               {req_ready, busy, done, wr_ready, rd_valid, ram_wren}, ram_addr, ram_wdata, BASE);
    else n_pass++;
    for (int i = 0; i < NW; i++) begin
      want = (i < 5) ? 32'hA500_0000 + 32'(i) : 32'hDEAD_0000 + 32'(int'(BASE) + i);
      n_total++;
      if (mem[int'(BASE) + i] !== want)
        $display("FAIL abort_mem%0d: got %h want %h", i, mem[int'(BASE) + i], want);
      else n_pass++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_dir   = 1'b0;
    rd_ready  = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    load      = 1'b0;
    @(negedge clk);
    test_reset();
    test_read_stream();
    test_read_stall();
    test_write();
    test_held_req();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/n64_si_dma_ctrl.md
Name: n64_si_dma_ctrl

Overview:
- Serial-interface DMA engine on the word (port-B) side of the PIF RAM.
- On each accepted request, moves one 64-byte PIF block (16 x 32-bit words) in one direction:
  - PIF RAM to an outbound word stream (SI read), or
  - an inbound word stream to PIF RAM (SI write).
- Drives the RAM port-B address, write-enable and write-data pins. Consumes RAM read data, which has a fixed 1-clock read latency.

Parameters:
- ADDR_W, 9, word-address width of the PIF RAM port B.
- BURST_WORDS, 16, words per transfer; must be a power of two and at most 2^ADDR_W.
- BASE_WORD, 9'h1F0, first word address of the PIF block (byte 0x7C0).

Ports:
- clk  in  1  single clock; also clocks the PIF RAM port B.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  transfer request.
- req_dir  in  1  0 = RAM to stream (read); 1 = stream to RAM (write).
- req_ready  out  1  high only in IDLE.
- ram_addr  out  ADDR_W  port-B word address.
- ram_wren  out  1  port-B write enable.
- ram_wdata  out  32  port-B write data.
- ram_rdata  in  32  port-B read data; valid the clock after its address was presented.
- rd_data  out  32  outbound word.
- rd_valid  out  1  outbound valid.
- rd_ready  in  1  outbound ready.
- wr_data  in  32  inbound word.
- wr_valid  in  1  inbound valid.
- wr_ready  out  1  inbound ready.
- busy  out  1  high in READ, WRITE or DONE.
- done  out  1  one-clock pulse at the end of a burst.

Behaviour:
- Reset values: state = IDLE; all counters = 0; output FIFO empty. Outputs:
  - req_ready = 1
  - ram_wren = 0, ram_addr = BASE_WORD, ram_wdata = 0
  - rd_valid = 0, wr_ready = 0, busy = 0, done = 0
- Reset asserted mid-burst aborts immediately. No further RAM writes occur. Partially written words stay written.
- Handshake rule: a transfer occurs on a clock edge where valid && ready. Once valid is asserted, rd_data/rd_valid are held stable until accepted.
- IDLE:
  - On req_valid, latch req_dir.
  - Clear the issue counter (icnt) and the completion counter (ccnt).
  - Go to READ or WRITE on the next clock.
- READ: output FIFO is 2 entries deep. inflight is 1 bit: set when a read address is issued, and its data is pushed into the FIFO on the next clock.
  - Issue a read when icnt < BURST_WORDS and (fifo_count + inflight − pop_this_cycle) < 2.
  - On issue: ram_addr = BASE_WORD + icnt (modulo 2^ADDR_W); icnt increments.
  - rd_valid = FIFO not empty; rd_data = FIFO head.
  - Each pop increments ccnt.
  - When ccnt reaches BURST_WORDS, go to DONE.
  - With rd_ready held high, the first rd_valid appears 2 clocks after the request is accepted, then one word per clock.
- WRITE:
  - wr_ready = 1 while ccnt < BURST_WORDS.
  - On an accepted word, in the same clock: ram_wren = 1, ram_addr = BASE_WORD + ccnt, ram_wdata = wr_data. ccnt increments.
  - ram_wren = 0 whenever no word is accepted.
  - After the 16th word, go to DONE.
- DONE: done = 1 for exactly one clock, busy = 1, then IDLE.
- Counters are ADDR_W+1 bits wide; no overflow is possible.
- req_valid outside IDLE is ignored (req_ready = 0). No request is queued.
- In READ, wr_data/wr_valid are ignored. In WRITE, rd_valid stays 0.

Decomposition:
- Shared package n64_pif_pkg holds:
  - PIF_BASE_WORD, PIF_BURST_WORDS, PIF_ADDR_W
  - the state encoding: IDLE = 0, READ = 1, WRITE = 2, DONE = 3
  - the SI_DIR_READ / SI_DIR_WRITE constants
- One sub-module is natural: si_word_fifo2, a 2-entry register FIFO with push/pop/count, used for the read path.

Test Plan:
- Read burst, rd_ready always 1, RAM words 0x1F0..0x1FF preloaded with value = address: rd_data 0x1F0..0x1FF on 16 consecutive clocks, first rd_valid 2 clocks after accept; done pulse follows; no ram_wren.
- Read burst, rd_ready toggling 1,0,0,1: no word is lost or duplicated; rd_data is stable while stalled; at most 2 reads are outstanding.
- Write burst, wr_data = 0xA5000000 + i with gaps in wr_valid: ram_wren fires 16 times at addresses 0x1F0..0x1FF with matching data; done after the last write.
- req_valid held during a burst: the second transfer starts only after done, when state returns to IDLE.
- Reset after the 5th write word: only 0x1F0..0x1F4 are written; all outputs return to reset values the next clock.
- Back-to-back read then write requests: state returns to IDLE between bursts; busy drops for ≥1 clock.
